// File: rtl/ov7670_sim_source.sv
// ---------------------------------------------------------------------------
// ov7670_sim_source
//
// Synthesizable stand-in for an OV7670 camera sensor. It produces OV7670-style
// frame timing on vsync/href/px_data with RGB565 pixels sent as two bytes,
// high byte first. Deterministic test patterns let the downstream capture,
// framebuffer and address logic be exercised without a real sensor.
//
// Ports
//   pclk        in   pixel clock, every output is registered on its rising edge
//   rst         in   asynchronous reset, active low
//   en          in   1 = run frames back to back, 0 = stop at the next frame boundary
//   pattern     in   0 colour bars, 1 solid colour, 2 8x8 checker, 3 raw x/y bytes
//   color565    in   colour used by the solid pattern
//   vsync       out  frame sync pulse
//   href        out  high while line bytes are valid
//   px_data     out  pixel byte, forced to 0 whenever href is low
//   frame_start out  one-cycle pulse on the first vsync cycle of every frame
//   frame_cnt   out  frames started since reset, wraps 255 -> 0
// ---------------------------------------------------------------------------
module ov7670_sim_source #(
    parameter int H_PX    = 160,
    parameter int V_LINES = 120,
    parameter int VS_CYC  = 16,
    parameter int VBP_CYC = 32,
    parameter int HBL_CYC = 16,
    parameter int VFP_CYC = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [15:0] color565,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  px_data,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    // Terminal counts for each timing phase, pre-sized to the 16-bit counters.
    localparam logic [15:0] VS_LAST  = 16'(VS_CYC - 1);
    localparam logic [15:0] VBP_LAST = 16'(VBP_CYC - 1);
    localparam logic [15:0] HBL_LAST = 16'(HBL_CYC - 1);
    localparam logic [15:0] VFP_LAST = 16'(VFP_CYC - 1);
    localparam logic [15:0] B_LAST   = 16'(2 * H_PX - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_LINES - 1);
    localparam logic [15:0] BAR_W    = 16'(H_PX / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_LINE,
        S_HBLANK,
        S_VFP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] b;
    logic [15:0] y;
    logic [1:0]  pat_q;
    logic [15:0] col_q;
    logic        start_frame;

    // Byte for byte-index bidx on line yl of the latched pattern. The raw
    // pattern is built as a pseudo-RGB565 word {x, y} so that the common
    // high/low byte split below serves every pattern.
    function automatic logic [7:0] pixel_byte(input logic [1:0]  pat,
                                              input logic [15:0] col,
                                              input logic [15:0] bidx,
                                              input logic [7:0]  yl);
        logic [15:0] x;
        logic [15:0] rgb;
        logic [2:0]  bar;
        x   = {1'b0, bidx[15:1]};
        bar = 3'(x / BAR_W);
        rgb = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    rgb = 16'hFFFF;
                    3'd1:    rgb = 16'hFFE0;
                    3'd2:    rgb = 16'h07FF;
                    3'd3:    rgb = 16'h07E0;
                    3'd4:    rgb = 16'hF81F;
                    3'd5:    rgb = 16'hF800;
                    3'd6:    rgb = 16'h001F;
                    default: rgb = 16'h0000;
                endcase
            end
            2'd1:    rgb = col;
            2'd2:    rgb = (x[3] ^ yl[3]) ? 16'hFFFF : 16'h0000;
            default: rgb = {x[7:0], yl};
        endcase
        return bidx[0] ? rgb[7:0] : rgb[15:8];
    endfunction

    // A new frame may begin from IDLE, or straight out of the last front-porch
    // cycle so that back-to-back frames have no extra gap.
    always_comb begin
        start_frame = 1'b0;
        if (en && ((state == S_IDLE) || ((state == S_VFP) && (cnt == VFP_LAST))))
            start_frame = 1'b1;
    end

    // Frame timing FSM. Outputs are registered alongside the state so each
    // output reflects the state being entered, and px_data is computed from
    // the byte index about to be presented.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            b           <= 16'd0;
            y           <= 16'd0;
            pat_q       <= 2'd0;
            col_q       <= 16'd0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            px_data     <= 8'd0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_start <= 1'b0;
            if (start_frame) begin
                state       <= S_VSYNC;
                cnt         <= 16'd0;
                vsync       <= 1'b1;
                frame_start <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
                pat_q       <= pattern;
                col_q       <= color565;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt <= 16'd0;
                    end
                    S_VSYNC: begin
                        if (cnt == VS_LAST) begin
                            state <= S_VBP;
                            vsync <= 1'b0;
                            cnt   <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_VBP: begin
                        if (cnt == VBP_LAST) begin
                            state   <= S_LINE;
                            cnt     <= 16'd0;
                            b       <= 16'd0;
                            y       <= 16'd0;
                            href    <= 1'b1;
                            px_data <= pixel_byte(pat_q, col_q, 16'd0, 8'd0);
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_LINE: begin
                        if (b == B_LAST) begin
                            state   <= S_HBLANK;
                            cnt     <= 16'd0;
                            href    <= 1'b0;
                            px_data <= 8'd0;
                        end else begin
                            b       <= b + 16'd1;
                            px_data <= pixel_byte(pat_q, col_q, b + 16'd1, y[7:0]);
                        end
                    end
                    S_HBLANK: begin
                        if (cnt == HBL_LAST) begin
                            cnt <= 16'd0;
                            if (y == Y_LAST) begin
                                state <= S_VFP;
                            end else begin
                                state   <= S_LINE;
                                y       <= y + 16'd1;
                                b       <= 16'd0;
                                href    <= 1'b1;
                                px_data <= pixel_byte(pat_q, col_q, 16'd0, y[7:0] + 8'd1);
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_VFP: begin
                        // The terminal cycle with en high is taken by start_frame.
                        if (cnt == VFP_LAST) begin
                            state <= S_IDLE;
                            cnt   <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_sim_source.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sim_source
//
// Bench for ov7670_sim_source. A small-parameter instance covers the pattern,
// latching, stop and reset behaviour over several short frames; a
// default-parameter instance covers one full 160x120 frame and its timing.
// Expected waveforms come from a position-in-frame timing model and a table
// of hand-computed pixel bytes.
// ---------------------------------------------------------------------------
module tb_ov7670_sim_source;

    // Small instance geometry: bar width 3, checker spans 3x3 blocks.
    localparam int SH   = 24;
    localparam int SV   = 20;
    localparam int SVS  = 5;
    localparam int SVBP = 7;
    localparam int SHBL = 3;
    localparam int SVFP = 6;

    typedef struct {
        int         slot;
        int         line;
        int         pair;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [1:0]  pattern  = 2'd0;
    logic [15:0] color565 = 16'd0;
    logic        vsync, href, frame_start;
    logic [7:0]  px_data, frame_cnt;

    logic        rst_d  = 1'b1;
    logic        en_d   = 1'b0;
    logic [1:0]  pattern_d  = 2'd0;
    logic [15:0] color565_d = 16'd0;
    logic        vsync_d, href_d, frame_start_d;
    logic [7:0]  px_data_d, frame_cnt_d;

    logic        use_def = 1'b0;
    logic        mon_vsync, mon_href, mon_fs;
    logic [7:0]  mon_px, mon_cnt;

    logic [7:0]  cap [0:119][0:319];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pix;

    ov7670_sim_source #(
        .H_PX(SH), .V_LINES(SV), .VS_CYC(SVS), .VBP_CYC(SVBP), .HBL_CYC(SHBL), .VFP_CYC(SVFP)
    ) dut (
        .pclk(pclk), .rst(rst), .en(en), .pattern(pattern), .color565(color565),
        .vsync(vsync), .href(href), .px_data(px_data),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    ov7670_sim_source dut_def (
        .pclk(pclk), .rst(rst_d), .en(en_d), .pattern(pattern_d), .color565(color565_d),
        .vsync(vsync_d), .href(href_d), .px_data(px_data_d),
        .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
    );

    // Free-running pixel clock shared by both instances.
    always #5 pclk = ~pclk;

    // Observation point: the frame walker watches whichever instance is active.
    always_comb begin
        mon_vsync = vsync;
        mon_href  = href;
        mon_px    = px_data;
        mon_fs    = frame_start;
        mon_cnt   = frame_cnt;
        if (use_def) begin
            mon_vsync = vsync_d;
            mon_href  = href_d;
            mon_px    = px_data_d;
            mon_fs    = frame_start_d;
            mon_cnt   = frame_cnt_d;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] p, input logic [15:0] c);
        en       = e;
        pattern  = p;
        color565 = c;
    endtask

    task automatic addVec(input int s, input int l, input int p,
                          input logic [7:0] h, input logic [7:0] lo);
        vec_t v;
        v.slot = s; v.line = l; v.pair = p; v.hi = h; v.lo = lo;
        vecs.push_back(v);
    endtask

    // Walks one frame starting at the current negedge (expected frame_start
    // cycle), comparing vsync/href/frame_start against the timing model and
    // capturing line bytes. Ends on the negedge of the last frame cycle.
    task automatic walkFrame(input int hp, input int vl, input int vs, input int vbp,
                             input int hbl, input int vfp, output int pixels);
        int len, per, r, ln, off, hcnt, e_t, e_z, e_fs;
        logic ev, eh;
        for (int i = 0; i < vl; i++)
            for (int j = 0; j < 2 * hp; j++)
                cap[i][j] = 8'hxx;
        per = 2 * hp + hbl;
        len = vs + vbp + vl * per + vfp;
        hcnt = 0; e_t = 0; e_z = 0; e_fs = 0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge pclk);
            ev = 1'b0; eh = 1'b0; ln = 0; off = 0;
            r = k;
            if (r < vs) begin
                ev = 1'b1;
            end else begin
                r = r - vs;
                if (r >= vbp) begin
                    r  = r - vbp;
                    ln = r / per;
                    off = r % per;
                    if (ln < vl && off < 2 * hp) eh = 1'b1;
                end
            end
            if (mon_vsync !== ev || mon_href !== eh) e_t++;
            if (!eh && mon_px !== 8'd0) e_z++;
            if (mon_fs !== (k == 0)) e_fs++;
            if (mon_href === 1'b1) hcnt++;
            if (eh) cap[ln][off] = mon_px;
        end
        pixels = hcnt / 2;
        checkOutput("frame vsync/href timing errors", e_t, 0);
        checkOutput("px_data nonzero outside href", e_z, 0);
        checkOutput("frame_start pulse errors", e_fs, 0);
    endtask

    task automatic checkVectors(input int slot);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].slot == slot) begin
                checkOutput($sformatf("slot %0d line %0d pair %0d hi", slot, vecs[i].line, vecs[i].pair),
                            cap[vecs[i].line][2 * vecs[i].pair], vecs[i].hi);
                checkOutput($sformatf("slot %0d line %0d pair %0d lo", slot, vecs[i].line, vecs[i].pair),
                            cap[vecs[i].line][2 * vecs[i].pair + 1], vecs[i].lo);
            end
        end
    endtask

    task automatic scanSolid(input int hp, input int vl, input logic [7:0] h, input logic [7:0] lo);
        int errs;
        errs = 0;
        for (int i = 0; i < vl; i++)
            for (int j = 0; j < hp; j++)
                if (cap[i][2 * j] !== h || cap[i][2 * j + 1] !== lo) errs++;
        checkOutput("solid frame pixel errors", errs, 0);
    endtask

    initial begin
        int errs, fs_seen;

        // Slot 1: raw x/y, small.
        addVec(1, 5, 9, 8'h09, 8'h05);   addVec(1, 0, 0, 8'h00, 8'h00);
        addVec(1, 19, 23, 8'h17, 8'h13); addVec(1, 12, 7, 8'h07, 8'h0C);
        // Slot 2: solid F81F, small.
        addVec(2, 0, 0, 8'hF8, 8'h1F);   addVec(2, 10, 12, 8'hF8, 8'h1F);
        addVec(2, 19, 23, 8'hF8, 8'h1F);
        // Slot 3: colour bars, bar width 3.
        addVec(3, 0, 0, 8'hFF, 8'hFF);   addVec(3, 0, 2, 8'hFF, 8'hFF);
        addVec(3, 0, 3, 8'hFF, 8'hE0);   addVec(3, 0, 6, 8'h07, 8'hFF);
        addVec(3, 0, 9, 8'h07, 8'hE0);   addVec(3, 0, 12, 8'hF8, 8'h1F);
        addVec(3, 0, 15, 8'hF8, 8'h00);  addVec(3, 0, 18, 8'h00, 8'h1F);
        addVec(3, 0, 21, 8'h00, 8'h00);  addVec(3, 19, 5, 8'hFF, 8'hE0);
        // Slot 4: 8x8 checker.
        addVec(4, 0, 0, 8'h00, 8'h00);   addVec(4, 0, 8, 8'hFF, 8'hFF);
        addVec(4, 0, 16, 8'h00, 8'h00);  addVec(4, 8, 0, 8'hFF, 8'hFF);
        addVec(4, 8, 8, 8'h00, 8'h00);   addVec(4, 15, 7, 8'hFF, 8'hFF);
        addVec(4, 16, 15, 8'hFF, 8'hFF);
        // Slot 5: colour bars, default geometry (bar width 20).
        addVec(5, 0, 19, 8'hFF, 8'hFF);  addVec(5, 0, 20, 8'hFF, 8'hE0);
        addVec(5, 3, 39, 8'hFF, 8'hE0);  addVec(5, 7, 40, 8'h07, 8'hFF);
        addVec(5, 60, 100, 8'hF8, 8'h00); addVec(5, 50, 139, 8'h00, 8'h1F);
        addVec(5, 119, 140, 8'h00, 8'h00); addVec(5, 119, 159, 8'h00, 8'h00);
        // Slot 6: fresh frame after reset, solid 1234.
        addVec(6, 3, 3, 8'h12, 8'h34);   addVec(6, 19, 23, 8'h12, 8'h34);

        // Reset state and idle with en low.
        #2 rst = 1'b0; rst_d = 1'b0;
        #1;
        checkOutput("reset vsync", vsync, 0);
        checkOutput("reset href", href, 0);
        checkOutput("reset px_data", px_data, 0);
        checkOutput("reset frame_start", frame_start, 0);
        checkOutput("reset frame_cnt", frame_cnt, 0);
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        errs = 0; fs_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (vsync !== 1'b0 || href !== 1'b0 || px_data !== 8'd0) errs++;
            if (frame_start !== 1'b0) fs_seen++;
        end
        checkOutput("idle outputs nonzero", errs, 0);
        checkOutput("idle frame_start count", fs_seen, 0);
        checkOutput("idle frame_cnt", frame_cnt, 0);

        // Frame 1: raw pattern; solid requested mid-frame must wait.
        applyStimulus(1'b1, 2'd3, 16'h0000);
        @(negedge pclk);
        checkOutput("frame_start latency", frame_start, 1);
        checkOutput("vsync at frame start", vsync, 1);
        checkOutput("frame_cnt frame 1", frame_cnt, 1);
        fork
            walkFrame(SH, SV, SVS, SVBP, SHBL, SVFP, pix);
            begin
                repeat (400) @(negedge pclk);
                applyStimulus(1'b1, 2'd1, 16'hF81F);
            end
        join
        checkOutput("frame 1 pixel count", pix, SH * SV);
        checkVectors(1);

        // Frame 2 follows immediately: solid; bars requested mid-frame.
        @(negedge pclk);
        checkOutput("frame interval frame_start", frame_start, 1);
        checkOutput("frame_cnt frame 2", frame_cnt, 2);
        fork
            walkFrame(SH, SV, SVS, SVBP, SHBL, SVFP, pix);
            begin
                repeat (300) @(negedge pclk);
                applyStimulus(1'b1, 2'd0, 16'h0000);
            end
        join
        checkVectors(2);
        scanSolid(SH, SV, 8'hF8, 8'h1F);

        // Frame 3: bars; en drops during line 10, frame must still complete.
        @(negedge pclk);
        checkOutput("frame_start frame 3", frame_start, 1);
        checkOutput("frame_cnt frame 3", frame_cnt, 3);
        fork
            walkFrame(SH, SV, SVS, SVBP, SHBL, SVFP, pix);
            begin
                repeat (SVS + SVBP + 10 * (2 * SH + SHBL) + 6) @(negedge pclk);
                applyStimulus(1'b0, 2'd2, 16'h0000);
            end
        join
        checkOutput("frame 3 pixel count", pix, SH * SV);
        checkVectors(3);
        errs = 0; fs_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (vsync !== 1'b0 || href !== 1'b0 || px_data !== 8'd0) errs++;
            if (frame_start !== 1'b0) fs_seen++;
        end
        checkOutput("stopped outputs nonzero", errs, 0);
        checkOutput("stopped frame_start count", fs_seen, 0);
        checkOutput("stopped frame_cnt", frame_cnt, 3);

        // Frame 4: checker from IDLE.
        applyStimulus(1'b1, 2'd2, 16'h0000);
        @(negedge pclk);
        checkOutput("restart frame_start", frame_start, 1);
        checkOutput("frame_cnt frame 4", frame_cnt, 4);
        walkFrame(SH, SV, SVS, SVBP, SHBL, SVFP, pix);
        checkVectors(4);

        // Frame 5: reset pulse during line 0, then a fresh frame.
        @(negedge pclk);
        checkOutput("frame_start frame 5", frame_start, 1);
        checkOutput("frame_cnt frame 5", frame_cnt, 5);
        repeat (20) @(negedge pclk);
        checkOutput("href before reset", href, 1);
        #2 rst = 1'b0;
        applyStimulus(1'b1, 2'd1, 16'h1234);
        #1;
        checkOutput("async reset href", href, 0);
        checkOutput("async reset px_data", px_data, 0);
        checkOutput("async reset vsync", vsync, 0);
        checkOutput("async reset frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        checkOutput("post-reset frame_start", frame_start, 1);
        checkOutput("post-reset frame_cnt", frame_cnt, 1);
        walkFrame(SH, SV, SVS, SVBP, SHBL, SVFP, pix);
        checkOutput("post-reset pixel count", pix, SH * SV);
        checkVectors(6);
        applyStimulus(1'b0, 2'd0, 16'h0000);

        // Default geometry: one full 160x120 colour-bar frame.
        @(negedge pclk);
        use_def    = 1'b1;
        rst_d      = 1'b1;
        en_d       = 1'b1;
        pattern_d  = 2'd0;
        color565_d = 16'h0000;
        @(negedge pclk);
        checkOutput("default frame_start", frame_start_d, 1);
        checkOutput("default frame_cnt 1", frame_cnt_d, 1);
        walkFrame(160, 120, 16, 32, 16, 32, pix);
        checkOutput("default pixel count", pix, 19200);
        checkVectors(5);
        @(negedge pclk);
        checkOutput("default 40400-cycle frame_start", mon_fs, 1);
        checkOutput("default frame_cnt 2", mon_cnt, 2);
        en_d = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
